// File: rtl/tx_filt_ctrl.sv
// Symbol-rate to sample-rate controller for the TX pulse-shaping filter: buffers symbols,
// inserts OSR-1 zeros between them and flushes the filter with zeros on underrun.
// Optional: define TX_FILT_CTRL_UNDERRUN_CNT_EN to add a saturating 16-bit underrun counter.
module tx_filt_ctrl #(
    parameter int OSR        = 4,
    parameter int FLUSH_LEN  = 21,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [17:0] sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [17:0] x_out,
    output logic               sym_strobe,
    output logic               busy,
    output logic               underrun
`ifdef TX_FILT_CTRL_UNDERRUN_CNT_EN
    ,
    output logic        [15:0] underrun_cnt
`endif
);

    localparam int PH_W = $clog2(OSR);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state, state_nxt;
    logic [PH_W-1:0]    ph, ph_nxt, ph_inc;
    logic [7:0]         flush_cnt, flush_nxt;
    logic signed [17:0] x_nxt;
    logic               strobe_nxt, underrun_nxt;

    logic signed [17:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic               full, empty, push, pop, slot;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // Ready is forced low while reset is held so nothing is accepted into a clearing FIFO.
    assign sym_ready = !full && !reset;
    assign push      = sym_valid && sym_ready;
    assign busy      = (state != IDLE);
    assign slot      = (ph == '0);
    assign ph_inc    = (ph == PH_W'(OSR - 1)) ? '0 : ph + PH_W'(1);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        ph_nxt       = ph;
        flush_nxt    = flush_cnt;
        pop          = 1'b0;
        x_nxt        = '0;
        strobe_nxt   = 1'b0;
        underrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                ph_nxt    = '0;
                flush_nxt = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    x_nxt      = mem[rd_ptr];
                    strobe_nxt = 1'b1;
                    ph_nxt     = PH_W'(1);
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                ph_nxt = ph_inc;
                if (slot) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        x_nxt      = mem[rd_ptr];
                        strobe_nxt = 1'b1;
                    end else begin
                        underrun_nxt = 1'b1;
                        flush_nxt    = 8'd1;
                        state_nxt    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                ph_nxt = ph_inc;
                // A fresh symbol at a slot boundary wins over finishing the drain.
                if (slot && !empty) begin
                    pop        = 1'b1;
                    x_nxt      = mem[rd_ptr];
                    strobe_nxt = 1'b1;
                    flush_nxt  = '0;
                    state_nxt  = RUN;
                end else if (flush_cnt == 8'(FLUSH_LEN)) begin
                    flush_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    flush_nxt = flush_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ph         <= '0;
            flush_cnt  <= '0;
            x_out      <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ph         <= ph_nxt;
            flush_cnt  <= flush_nxt;
            x_out      <= x_nxt;
            sym_strobe <= strobe_nxt;
            underrun   <= underrun_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: symbol storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sym_in;
    end

`ifdef TX_FILT_CTRL_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (underrun_nxt && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_filt_ctrl.sv
// Self-checking bench for tx_filt_ctrl: directed scenarios plus random traffic compared
// against a queue-based sample-schedule model (covers TX_FILT_CTRL_UNDERRUN_CNT_EN when defined).
module tb_tx_filt_ctrl;

    localparam int OSR        = 4;
    localparam int FLUSH_LEN  = 21;
    localparam int FIFO_DEPTH = 4;

    logic               clk;
    logic               reset;
    logic signed [17:0] sym_in;
    logic               sym_valid;
    logic               sym_ready;
    logic signed [17:0] x_out;
    logic               sym_strobe;
    logic               busy;
    logic               underrun;
`ifdef TX_FILT_CTRL_UNDERRUN_CNT_EN
    logic        [15:0] underrun_cnt;
`endif

    tx_filt_ctrl #(
        .OSR       (OSR),
        .FLUSH_LEN (FLUSH_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .x_out     (x_out),
        .sym_strobe(sym_strobe),
        .busy      (busy),
        .underrun  (underrun)
`ifdef TX_FILT_CTRL_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: symbol queue, whether samples are being produced, clocks since the
    // last symbol slot, and how many drain zeros have been produced after an underrun.
    logic signed [17:0] q[$];
    bit                 m_active;
    bit                 m_drain;
    int                 age;
    int                 drained;
    int                 m_ucnt;
    logic signed [17:0] e_x;
    bit                 e_strobe;
    bit                 e_und;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_active = 0;
        m_drain  = 0;
        age      = 0;
        drained  = 0;
        m_ucnt   = 0;
        e_x      = '0;
        e_strobe = 0;
        e_und    = 0;
    endtask

    task automatic model_edge(input bit v, input logic signed [17:0] d);
        bit take;
        bit is_slot;
        take     = v && (q.size() < FIFO_DEPTH);
        e_x      = '0;
        e_strobe = 0;
        e_und    = 0;
        if (!m_active) begin
            if (q.size() > 0) begin
                e_x      = q.pop_front();
                e_strobe = 1;
                m_active = 1;
                m_drain  = 0;
                age      = 0;
            end
        end else begin
            age++;
            is_slot = (age == OSR);
            if (is_slot) age = 0;
            if (is_slot && q.size() > 0) begin
                e_x      = q.pop_front();
                e_strobe = 1;
                m_drain  = 0;
            end else if (!m_drain) begin
                if (is_slot) begin
                    e_und   = 1;
                    m_drain = 1;
                    drained = 1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end else if (drained == FLUSH_LEN) begin
                m_active = 0;
                m_drain  = 0;
            end else begin
                drained++;
            end
        end
        if (take) q.push_back(d);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"},      x_out,      e_x);
        check({tag, "_strobe"}, sym_strobe, e_strobe);
        check({tag, "_und"},    underrun,   e_und);
        check({tag, "_busy"},   busy,       m_active);
        check({tag, "_ready"},  sym_ready,  (q.size() < FIFO_DEPTH));
`ifdef TX_FILT_CTRL_UNDERRUN_CNT_EN
        check({tag, "_ucnt"},   underrun_cnt, m_ucnt);
`endif
    endtask

    task automatic step(input bit v, input logic signed [17:0] d, input string tag);
        sym_valid = v;
        sym_in    = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        sym_valid = 1'b0;
        check_outputs(tag);
    endtask

    // Holds sym_valid high with the same symbol until it is accepted (bounded).
    task automatic send(input logic signed [17:0] d, input string tag);
        bit took;
        int tries;
        took  = 0;
        tries = 0;
        while (!took && tries < 100) begin
            took = (q.size() < FIFO_DEPTH);
            step(1'b1, d, tag);
            tries++;
        end
        check({tag, "_send_timeout"}, took, 1);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, tag);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        sym_valid = 1'b0;
        #1;
        model_clear();
        check({tag, "_rst_x"},      x_out,      0);
        check({tag, "_rst_strobe"}, sym_strobe, 0);
        check({tag, "_rst_und"},    underrun,   0);
        check({tag, "_rst_busy"},   busy,       0);
        check({tag, "_rst_ready"},  sym_ready,  0);
`ifdef TX_FILT_CTRL_UNDERRUN_CNT_EN
        check({tag, "_rst_ucnt"},   underrun_cnt, 0);
`endif
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_rel_ready"}, sym_ready, 1);
        check({tag, "_rel_busy"},  busy,      0);
    endtask

    initial begin
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_in    = '0;
        model_clear();

        // Single symbol, zero insertion, underrun, full flush back to idle.
        do_reset("init");
        send(18'sd1000, "single");
        idle(OSR + FLUSH_LEN + 6, "single_tail");

        // Back-to-back stream 1..8 with valid held high.
        for (int i = 1; i <= 8; i++) send(18'(i), "stream");
        idle(OSR + FLUSH_LEN + 6, "stream_tail");

        // Push harder than the slot rate so the FIFO fills and ready drops.
        for (int i = 0; i < 10; i++) send(18'(100 + i), "full");
        idle(OSR + FLUSH_LEN + 6, "full_tail");

        // Underrun, then a new symbol six clocks into the flush.
        begin
            int guard;
            send(18'sd77, "flush_pre");
            guard = 0;
            while (!e_und && guard < 50) begin
                step(1'b0, '0, "flush_wait");
                guard++;
            end
            check("flush_seen_underrun", e_und, 1);
            idle(6, "flush_mid");
            send(-18'sd500, "flush_new");
            idle(2 * OSR, "flush_resume");
            check("flush_abandoned_busy", busy, 1);
            idle(OSR + FLUSH_LEN + 6, "flush_tail");
        end

        // Reset asynchronously while three symbols are still buffered mid-run.
        for (int i = 0; i < 4; i++) send(18'(300 + i), "midrun");
        step(1'b0, '0, "midrun_gap");
        check("midrun_buffered", q.size(), 3);
        do_reset("midrun");
        idle(OSR + 2, "midrun_after");

        // Random traffic of varying density.
        for (int seg = 0; seg < 6; seg++) begin
            int dens;
            dens = 1 + (seg % 4);
            for (int i = 0; i < 80; i++) begin
                bit                 v;
                logic signed [17:0] d;
                v = ($urandom_range(0, 7) < dens);
                d = 18'($urandom);
                step(v, d, "rand");
            end
        end
        idle(OSR + FLUSH_LEN + 6, "rand_tail");
        do_reset("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
